// File: rtl/scim_weight_loader.sv
// Weight loader for the SCIM macro: buffers one logical row of slices, then
// writes it as two physical rows (low bits, then high bits) with WRITE_EN/hold pairs.
module scim_weight_loader #(
  parameter int N_R     = 81,
  parameter int N_S     = 32,
  parameter int TWOS_IN = 0
) (
  input  logic               CLK,
  input  logic               RESET,
  input  logic               start,
  input  logic [6:0]         num_rows,
  input  logic               w_valid,
  input  logic [5:0]         w_data,
  output logic               w_ready,
  output logic [2*N_R-1:0]   WL,
  output logic [3*N_S-1:0]   DIN,
  output logic               WRITE_EN,
  output logic               busy,
  output logic               done,
  output logic               err
);

  localparam int SW  = (N_S > 1) ? $clog2(N_S) : 1;
  localparam int WLW = 2 * N_R;
  localparam int DW  = 3 * N_S;

  localparam logic [6:0]     NR_MAX = 7'(N_R);
  localparam logic [SW-1:0]  S_LAST = SW'(N_S - 1);
  localparam logic [WLW-1:0] WL_ONE = {{(WLW-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    IDLE,
    FILL,
    WR_LO,
    HOLD_LO,
    WR_HI,
    HOLD_HI
  } state_t;

  state_t         state_q;
  logic [6:0]     nrows_q;
  logic [6:0]     row_q;
  logic [SW-1:0]  slice_q;
  logic [DW-1:0]  lo_q, lo_d;
  logic [DW-1:0]  hi_q, hi_d;

  logic           w_ready_q;
  logic [WLW-1:0] wl_q;
  logic [DW-1:0]  din_q;
  logic           we_q;
  logic           busy_q;
  logic           done_q;
  logic           err_q;

  logic [5:0]     wt;
  logic [5:0]     neg;
  logic           accept;
  logic           legal;

  // Two's complement to sign-magnitude; -32 has no 5-bit magnitude and saturates.
  always_comb begin
    neg = -w_data;
    wt  = w_data;
    if (TWOS_IN != 0 && w_data[5]) begin
      wt = (w_data == 6'b100000) ? 6'b111111 : {1'b1, neg[4:0]};
    end
  end

  assign accept = (state_q == FILL) && w_valid && w_ready_q;
  assign legal  = (num_rows != 7'd0) && (num_rows <= NR_MAX);

  // Buffer view including the slice accepted this cycle, so WR_LO sees the last slice.
  always_comb begin
    lo_d = lo_q;
    hi_d = hi_q;
    if (accept) begin
      lo_d[3*int'(slice_q) +: 3] = wt[2:0];
      hi_d[3*int'(slice_q) +: 3] = wt[5:3];
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q   <= IDLE;
      nrows_q   <= '0;
      row_q     <= '0;
      slice_q   <= '0;
      lo_q      <= '0;
      hi_q      <= '0;
      w_ready_q <= 1'b0;
      wl_q      <= '0;
      din_q     <= '0;
      we_q      <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            if (legal) begin
              nrows_q   <= num_rows;
              row_q     <= '0;
              slice_q   <= '0;
              w_ready_q <= 1'b1;
              busy_q    <= 1'b1;
              state_q   <= FILL;
            end else begin
              err_q <= 1'b1;
            end
          end
        end
        FILL: begin
          lo_q <= lo_d;
          hi_q <= hi_d;
          if (accept) begin
            if (slice_q == S_LAST) begin
              slice_q   <= '0;
              w_ready_q <= 1'b0;
              we_q      <= 1'b1;
              wl_q      <= WL_ONE << {row_q, 1'b0};
              din_q     <= lo_d;
              state_q   <= WR_LO;
            end else begin
              slice_q <= slice_q + 1'b1;
            end
          end
        end
        WR_LO: begin
          we_q    <= 1'b0;
          state_q <= HOLD_LO;
        end
        HOLD_LO: begin
          we_q    <= 1'b1;
          wl_q    <= WL_ONE << {row_q, 1'b1};
          din_q   <= hi_q;
          state_q <= WR_HI;
        end
        WR_HI: begin
          we_q    <= 1'b0;
          state_q <= HOLD_HI;
        end
        HOLD_HI: begin
          wl_q  <= '0;
          din_q <= '0;
          if (row_q == nrows_q - 7'd1) begin
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= IDLE;
          end else begin
            row_q     <= row_q + 7'd1;
            slice_q   <= '0;
            w_ready_q <= 1'b1;
            state_q   <= FILL;
          end
        end
        default: begin
          state_q   <= IDLE;
          w_ready_q <= 1'b0;
          wl_q      <= '0;
          din_q     <= '0;
          we_q      <= 1'b0;
          busy_q    <= 1'b0;
        end
      endcase
    end
  end

  assign w_ready  = w_ready_q;
  assign WL       = wl_q;
  assign DIN      = din_q;
  assign WRITE_EN = we_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign err      = err_q;

endmodule

// File: doc/scim_weight_loader.md
SCIM_WEIGHT_LOADER -- requirements
Module: scim_weight_loader

Interface
REQ-001 N_R, 81, number of logical weight rows; physical rows = 2*N_R.
REQ-002 N_S, 32, number of slices per row; DIN width = 3*N_S.
REQ-003 TWOS_IN, 0, 1 = w_data is two's complement and is converted to sign-magnitude; 0 = w_data is passed through as sign-magnitude.
REQ-004 CLK  input  1  single clock; all state changes on rising edge.
REQ-005 RESET  input  1  synchronous, active-high reset.
REQ-006 start  input  1  begin load; sampled only in IDLE.
REQ-007 num_rows  input  7  logical rows to load, starting at row 0; legal 1..N_R.
REQ-008 w_valid  input  1  weight stream valid.
REQ-009 w_data  input  6  weight; bit 5 = sign, bits 4:0 = magnitude (after REQ-019 conversion).
REQ-010 w_ready  output  1  loader accepts w_data this cycle.
REQ-011 WL  output  2*N_R  one-hot physical word line to the macro.
REQ-012 DIN  output  3*N_S  write data to the macro.
REQ-013 WRITE_EN  output  1  macro write enable.
REQ-014 busy  output  1  high in any state other than IDLE.
REQ-015 done  output  1  one-cycle pulse on load completion.
REQ-016 err  output  1  one-cycle pulse on rejected start.

Function
REQ-017 States: IDLE, FILL, WR_LO, HOLD_LO, WR_HI, HOLD_HI; each transition on one rising edge.
REQ-018 IDLE: start=1 with 1<=num_rows<=N_R -> latch num_rows, row=0, slice=0, go FILL; illegal num_rows -> err=1 next cycle, stay IDLE; start outside IDLE ignored.
REQ-019 TWOS_IN=1: v>=0 -> {0,v[4:0]}; v<0 -> {1,|v|[4:0]}; -32 saturates to 6'b111111.
REQ-020 FILL: w_ready=1; a weight is accepted when w_valid & w_ready; weight for slice s is buffered: low bits [2:0] into lo[s*3+:3], high bits [5:3] into hi[s*3+:3]; slice increments per accept.
REQ-021 FILL -> WR_LO on the accept of slice N_S-1; w_ready=0 in all non-FILL states.
REQ-022 WR_LO: WRITE_EN=1, WL one-hot bit 2*row, DIN=lo.
REQ-023 HOLD_LO: WRITE_EN=0, WL and DIN unchanged from WR_LO (macro registers WRITE_EN and writes during the following cycle).
REQ-024 WR_HI: WRITE_EN=1, WL one-hot bit 2*row+1, DIN=hi; HOLD_HI: WRITE_EN=0, WL/DIN held.
REQ-025 HOLD_HI: if row==num_rows-1 -> IDLE with done=1 in that next cycle; else row+1, slice=0, FILL.
REQ-026 WL=0 and WRITE_EN=0 in IDLE and FILL; WL is never multi-hot; DIN=0 in IDLE.
REQ-027 Throughput: N_S+4 cycles per logical row with w_valid held high; w_valid low stalls FILL without loss.
REQ-028 Buffers lo/hi are overwritten each row; no residual data from a prior row reaches DIN.

Reset
REQ-029 RESET=1 at a rising edge -> IDLE, row=0, slice=0, lo=hi=0; WL=0, DIN=0, WRITE_EN=0, w_ready=0, busy=0, done=0, err=0.
REQ-030 RESET mid-operation (any state) discards the partial row and any pending write; no WRITE_EN pulse follows reset.
REQ-031 RESET has priority over start and w_valid in the same cycle.

Verification
REQ-032 num_rows=1, 32 weights 0..31 (TWOS_IN=0), w_valid constant -> WR_LO at cycle 33 after FILL entry with WL[0]=1, DIN slice s = s[2:0]; WR_HI WL[1]=1, DIN slice s = s[5:3]; done pulses once; 36 cycles total.
REQ-033 num_rows=81, random weights, macro model attached -> every physical row 0..161 written exactly once with correct halves; done after 81*36 cycles.
REQ-034 TWOS_IN=1, weights -1, -32, 31, 0 -> stored 6'b100001, 6'b111111, 6'b011111, 6'b000000.
REQ-035 start with num_rows=0 and with num_rows=82 -> err pulse, busy stays 0, WRITE_EN never asserted.
REQ-036 w_valid toggled randomly 50% during FILL -> same DIN contents as REQ-032; WRITE_EN only in WR_LO/WR_HI.
REQ-037 RESET asserted in WR_LO of row 3 -> next cycle all outputs 0, IDLE; new start loads row 0 correctly.
